// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control unit for a 5-stage CPU. It drives the stall, flush and
// bubble controls for the PC register, the IF/ID register and the ID/EX
// register. It detects load-use hazards and redirects from branches and jumps
// that are resolved in ID. It also tracks the multi-cycle multiply/divide unit
// (MDU), so an instruction that needs HI/LO waits in ID until the result is
// valid.
//
// Parameters
//   MUL_LAT   : cycles the MDU stays busy after a mult/multu (>= 1)
//   DIV_LAT   : cycles the MDU stays busy after a div/divu   (>= 1)
//   CNT_W     : busy counter width, 2**CNT_W > max(MUL_LAT, DIV_LAT)
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous reset, active-high; all outputs are 0 while high
//   rsD, rtD   in   source register fields of the instruction in ID
//   useRtD     in   instruction in ID reads rt
//   rtE        in   load destination register of the instruction in EX
//   memreadE   in   instruction in EX is a load
//   redirectD  in   taken branch or jump resolved in ID
//   mdu_startE in   mult/div instruction in EX this cycle
//   mdu_divE   in   1 = divide, 0 = multiply (qualified by mdu_startE)
//   mdu_useD   in   instruction in ID touches HI/LO or starts the MDU
//   stallF     out  hold the PC
//   stallD     out  hold IF/ID
//   flushD     out  clear IF/ID on the next edge
//   flushE     out  load a bubble into ID/EX on the next edge
//   mdu_busy   out  MDU result not yet valid (state register decode)
//
// Optional feature (macro PIPE_HAZARD_PERF_EN)
//   stall_cnt  out  [31:0] number of cycles with a stall, wraps modulo 2**32
//   flush_cnt  out  [31:0] number of cycles with flushD,  wraps modulo 2**32
//
// The stall and flush outputs are combinational from the FSM state and the
// current inputs, because they must take effect in the cycle the hazard is
// seen. The FSM state and the busy counter are the only control state.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRtD,
    input  logic [4:0] rtE,
    input  logic       memreadE,
    input  logic       redirectD,
    input  logic       mdu_startE,
    input  logic       mdu_divE,
    input  logic       mdu_useD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       flushE,
    output logic       mdu_busy
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    logic             lu_hazard_s;
    logic             mdu_hazard_s;
    logic             stall_s;
    logic             flush_s;

    // The counter is loaded with LAT-1. The busy state lasts while it counts
    // down to 0 inclusive, which gives exactly LAT busy cycles.
    function automatic logic [CNT_W-1:0] lat_init(input logic is_div);
        logic [CNT_W-1:0] v;
        if (is_div) begin
            v = CNT_W'(DIV_LAT - 1);
        end else begin
            v = CNT_W'(MUL_LAT - 1);
        end
        return v;
    endfunction

    // FSM state and busy counter registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: start on mdu_startE in RUN. A start seen while the
    // MDU is already busy is ignored, because ID stalling is expected to keep
    // a second MDU instruction out of EX.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (mdu_startE) begin
                    state_s = MDU_BUSY;
                    cnt_s   = lat_init(mdu_divE);
                end else begin
                    state_s = RUN;
                    cnt_s   = cnt_r;
                end
            end
            MDU_BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = RUN;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = MDU_BUSY;
                    cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = RUN;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Hazard detection. The MDU hazard also covers the start cycle itself,
    // because busy only rises on the following edge. $zero as a load target
    // never stalls.
    always_comb begin
        mdu_hazard_s = mdu_useD & ((state_r == MDU_BUSY) | mdu_startE);
        lu_hazard_s  = memreadE & (rtE != 5'd0) &
                       ((rtE == rsD) | (useRtD & (rtE == rtD)));
        stall_s      = mdu_hazard_s | lu_hazard_s;
        // A redirect from a stalled ID instruction uses stale operands. It is
        // therefore dropped and evaluated again once the stall clears.
        flush_s      = redirectD & ~stall_s;
    end

    // Output drive. clr overrides everything, so the pipeline is quiet during
    // reset even when the inputs look like a hazard.
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        mdu_busy = 1'b0;
        if (clr) begin
            stallF   = 1'b0;
            stallD   = 1'b0;
            flushD   = 1'b0;
            flushE   = 1'b0;
            mdu_busy = 1'b0;
        end else begin
            stallF   = stall_s;
            stallD   = stall_s;
            flushD   = flush_s;
            flushE   = stall_s;
            mdu_busy = (state_r == MDU_BUSY);
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Performance counters for stall and flush cycles. They wrap freely.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall_s) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush_s) begin
                flush_cnt <= flush_cnt + 32'd1;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed testbench for pipe_hazard_ctrl. Inputs change just after each
// falling edge. Outputs are sampled 1 time unit later, well away from the
// rising edge. Each check compares the vector
// {stallF, stallD, flushD, flushE, mdu_busy} with a hand-computed value.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       clr;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       useRtD;
    logic [4:0] rtE;
    logic       memreadE;
    logic       redirectD;
    logic       mdu_startE;
    logic       mdu_divE;
    logic       mdu_useD;
    logic       stallF;
    logic       stallD;
    logic       flushD;
    logic       flushE;
    logic       mdu_busy;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks;
    int fails;

    pipe_hazard_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .rsD        (rsD),
        .rtD        (rtD),
        .useRtD     (useRtD),
        .rtE        (rtE),
        .memreadE   (memreadE),
        .redirectD  (redirectD),
        .mdu_startE (mdu_startE),
        .mdu_divE   (mdu_divE),
        .mdu_useD   (mdu_useD),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .flushE     (flushE),
        .mdu_busy   (mdu_busy)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output patterns: {stallF, stallD, flushD, flushE, mdu_busy}
    localparam logic [4:0] IDLE  = 5'b00000;
    localparam logic [4:0] STALL = 5'b11010;
    localparam logic [4:0] FLUSH = 5'b00100;
    localparam logic [4:0] BUSY  = 5'b00001;
    localparam logic [4:0] BSTL  = 5'b11011;

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {stallF, stallD, flushD, flushE, mdu_busy};
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rsD = 5'd0; rtD = 5'd0; useRtD = 1'b0; rtE = 5'd0; memreadE = 1'b0;
        redirectD = 1'b0; mdu_startE = 1'b0; mdu_divE = 1'b0; mdu_useD = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        clr    = 1'b0;
        idle_inputs();
        #1;
        clr = 1'b1;
        // Hazard-looking inputs during reset must still give all zeros
        memreadE = 1'b1; rtE = 5'd5; rsD = 5'd5; redirectD = 1'b1; mdu_useD = 1'b1;
        mdu_startE = 1'b1;
        #1 chk("reset_forced_zero", IDLE);
        step(); idle_inputs(); clr = 1'b0; #1 chk("after_reset", IDLE);

        // Load-use on rs: one stall cycle, then clear
        step(); memreadE = 1'b1; rtE = 5'd5; rsD = 5'd5; #1 chk("lu_rs", STALL);
        step(); idle_inputs(); #1 chk("lu_rs_next", IDLE);
        // Register-0 destination never stalls
        step(); memreadE = 1'b1; rtE = 5'd0; rsD = 5'd0; rtD = 5'd0; useRtD = 1'b1;
        #1 chk("lu_r0", IDLE);
        // rt matches but rt is not a source
        step(); idle_inputs(); memreadE = 1'b1; rtE = 5'd7; rsD = 5'd3; rtD = 5'd7;
        #1 chk("lu_no_dep", IDLE);
        step(); useRtD = 1'b1; #1 chk("lu_rt", STALL);
        // Matching registers but no load
        step(); memreadE = 1'b0; #1 chk("no_load", IDLE);

        // Redirect alone flushes; with a load-use stall it is suppressed
        step(); idle_inputs(); redirectD = 1'b1; #1 chk("redirect", FLUSH);
        step(); memreadE = 1'b1; rtE = 5'd9; rsD = 5'd9; #1 chk("redirect_stalled", STALL);

        // Divide with a dependent instruction held in ID
        step(); idle_inputs(); mdu_startE = 1'b1; mdu_divE = 1'b1; mdu_useD = 1'b1;
        #1 chk("div_start", STALL);
        for (int i = 1; i <= 32; i++) begin
            step(); mdu_startE = 1'b0; mdu_divE = 1'b0;
            #1 chk($sformatf("div_busy_%0d", i), BSTL);
        end
        step(); #1 chk("div_done", IDLE);

        // Multiply with no user in ID: 4 busy cycles, no stall
        step(); idle_inputs(); mdu_startE = 1'b1; #1 chk("mul_start", IDLE);
        for (int i = 1; i <= 4; i++) begin
            step(); mdu_startE = 1'b0;
            #1 chk($sformatf("mul_busy_%0d", i), BUSY);
        end
        step(); #1 chk("mul_done", IDLE);

        // A start during busy must be ignored (no restart into a divide)
        step(); mdu_startE = 1'b1; #1 chk("mul2_start", IDLE);
        step(); mdu_divE = 1'b1; #1 chk("mul2_busy_1_restart", BUSY);
        for (int i = 2; i <= 4; i++) begin
            step(); mdu_startE = 1'b0; mdu_divE = 1'b0;
            #1 chk($sformatf("mul2_busy_%0d", i), BUSY);
        end
        step(); #1 chk("mul2_done", IDLE);

        // Reset in the middle of a divide acts immediately
        step(); mdu_startE = 1'b1; mdu_divE = 1'b1; #1 chk("div2_start", IDLE);
        for (int i = 1; i <= 9; i++) begin
            step(); mdu_startE = 1'b0; mdu_divE = 1'b0;
            #1 chk($sformatf("div2_busy_%0d", i), BUSY);
        end
        step(); #1 chk("div2_busy_10", BUSY);
        #1 clr = 1'b1; mdu_useD = 1'b1; memreadE = 1'b1; rtE = 5'd4; rsD = 5'd4;
        #1 chk("mid_reset", IDLE);
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        assert (stall_cnt === 32'd0 && flush_cnt === 32'd0) else begin
            fails++;
            $error("FAIL perf_clear observed=%0d/%0d expected=0/0", stall_cnt, flush_cnt);
        end
`endif
        step(); idle_inputs(); clr = 1'b0; #1 chk("post_reset", IDLE);
        step(); mdu_startE = 1'b1; #1 chk("mul3_start", IDLE);
        for (int i = 1; i <= 4; i++) begin
            step(); mdu_startE = 1'b0;
            #1 chk($sformatf("mul3_busy_%0d", i), BUSY);
        end
        step(); #1 chk("mul3_done", IDLE);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
